// File: rtl/morse_decoder.sv
// Morse receiver: synchronizes and tick-samples a serial on/off line, classifies mark/space runs
// and decodes letters S..Z to a 3-bit code with one-cycle valid/error strobes.
module morse_decoder #(
  parameter int TICK_DIV  = 25000000,
  parameter int GAP_TICKS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       morse_in,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       decode_error,
  output logic       busy
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, MARK, SPACE, DRAIN} state_t;

  state_t        state_reg, state_next;
  logic          sync1_reg, sync2_reg;
  logic [CW-1:0] div_reg;
  logic          tick;
  logic [2:0]    mark_len_reg, mark_len_next;
  logic [2:0]    space_len_reg, space_len_next;
  logic [3:0]    sym_reg, sym_next;
  logic [2:0]    sym_cnt_reg, sym_cnt_next;
  logic [2:0]    letter_reg, letter_next;
  logic          valid_reg, valid_next;
  logic          error_reg, error_next;
  logic [2:0]    mark_inc, space_inc;
  logic          match_hit;
  logic [2:0]    match_code;

  assign tick = (div_reg == CW'(TICK_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_reg     <= 1'b0;
      sync2_reg     <= 1'b0;
      div_reg       <= '0;
      state_reg     <= IDLE;
      mark_len_reg  <= 3'd0;
      space_len_reg <= 3'd0;
      sym_reg       <= 4'd0;
      sym_cnt_reg   <= 3'd0;
      letter_reg    <= 3'd0;
      valid_reg     <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      sync1_reg     <= morse_in;
      sync2_reg     <= sync1_reg;
      div_reg       <= tick ? '0 : div_reg + CW'(1);
      state_reg     <= state_next;
      mark_len_reg  <= mark_len_next;
      space_len_reg <= space_len_next;
      sym_reg       <= sym_next;
      sym_cnt_reg   <= sym_cnt_next;
      letter_reg    <= letter_next;
      valid_reg     <= valid_next;
      error_reg     <= error_next;
    end
  end

  // Run counters saturate rather than wrap so a long space can never alias a short one.
  assign mark_inc  = (mark_len_reg == 3'd7) ? mark_len_reg : mark_len_reg + 3'd1;
  assign space_inc = (space_len_reg == 3'd7) ? space_len_reg : space_len_reg + 3'd1;

  // Symbols are stored LSB-first, dash=1; the count disambiguates e.g. S (...) from T (-).
  always_comb begin
    match_hit  = 1'b1;
    match_code = 3'd0;
    case ({sym_cnt_reg, sym_reg})
      7'b011_0000: match_code = 3'd0;
      7'b001_0001: match_code = 3'd1;
      7'b011_0100: match_code = 3'd2;
      7'b100_1000: match_code = 3'd3;
      7'b011_0110: match_code = 3'd4;
      7'b100_1001: match_code = 3'd5;
      7'b100_1101: match_code = 3'd6;
      7'b100_0011: match_code = 3'd7;
      default:     match_hit  = 1'b0;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    mark_len_next  = mark_len_reg;
    space_len_next = space_len_reg;
    sym_next       = sym_reg;
    sym_cnt_next   = sym_cnt_reg;
    letter_next    = letter_reg;
    valid_next     = 1'b0;
    error_next     = 1'b0;
    if (tick) begin
      case (state_reg)
        IDLE: begin
          if (sync2_reg) begin
            state_next    = MARK;
            mark_len_next = 3'd1;
            sym_next      = 4'd0;
            sym_cnt_next  = 3'd0;
          end
        end
        MARK: begin
          if (sync2_reg) begin
            mark_len_next = mark_inc;
            if (mark_inc == 3'd4) begin
              error_next     = 1'b1;
              space_len_next = 3'd0;
              state_next     = DRAIN;
            end
          end else begin
            space_len_next = 3'd1;
            if (sym_cnt_reg == 3'd4) begin
              // The closing space of a fifth symbol already counts toward the drain gap.
              error_next = 1'b1;
              state_next = DRAIN;
            end else begin
              sym_next[sym_cnt_reg[1:0]] = (mark_len_reg != 3'd1);
              sym_cnt_next               = sym_cnt_reg + 3'd1;
              state_next                 = SPACE;
            end
          end
        end
        SPACE: begin
          if (sync2_reg) begin
            state_next    = MARK;
            mark_len_next = 3'd1;
          end else begin
            space_len_next = space_inc;
            if (space_inc == 3'(GAP_TICKS)) begin
              if (match_hit) begin
                letter_next = match_code;
                valid_next  = 1'b1;
              end else begin
                error_next = 1'b1;
              end
              sym_next     = 4'd0;
              sym_cnt_next = 3'd0;
              state_next   = IDLE;
            end
          end
        end
        DRAIN: begin
          if (sync2_reg) begin
            space_len_next = 3'd0;
          end else begin
            space_len_next = space_inc;
            if (space_inc == 3'(GAP_TICKS)) begin
              sym_next     = 4'd0;
              sym_cnt_next = 3'd0;
              state_next   = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign letter       = letter_reg;
  assign letter_valid = valid_reg;
  assign decode_error = error_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: directed letters plus random symbol streams, checked every bit period
// against a run-length/string model of the Morse letter rules.
module tb_morse_decoder;

  localparam int TICK_DIV  = 4;
  localparam int GAP_TICKS = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       morse_in = 1'b0;
  logic [2:0] letter;
  logic       letter_valid;
  logic       decode_error;
  logic       busy;

  morse_decoder #(.TICK_DIV(TICK_DIV), .GAP_TICKS(GAP_TICKS)) dut (
    .clock(clock), .reset(reset), .morse_in(morse_in),
    .letter(letter), .letter_valid(letter_valid), .decode_error(decode_error), .busy(busy)
  );

  always #5 clock = ~clock;

  int    n_checks = 0;
  int    n_fail   = 0;
  string patterns [8];

  // Model state: whether a letter or drain is in progress, current runs, and the letter so far.
  bit    m_in_letter, m_drain;
  int    m_mark, m_zero;
  string m_pat;
  int    exp_letter;
  bit    exp_valid, exp_err, exp_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_letter = 0; m_drain = 0; m_mark = 0; m_zero = 0; m_pat = "";
    exp_letter = 0; exp_valid = 0; exp_err = 0; exp_busy = 0;
  endtask

  task automatic model_step(input bit b);
    int hit;
    exp_valid = 0;
    exp_err   = 0;
    if (m_drain) begin
      m_zero = b ? 0 : m_zero + 1;
      if (m_zero >= GAP_TICKS) m_drain = 0;
    end else if (!m_in_letter) begin
      if (b) begin m_in_letter = 1; m_mark = 1; m_pat = ""; end
    end else if (b) begin
      if (m_mark == 0) m_mark = 1;
      else begin
        m_mark++;
        if (m_mark == 4) begin exp_err = 1; m_in_letter = 0; m_drain = 1; m_zero = 0; end
      end
    end else if (m_mark > 0) begin
      if (m_mark == 1) m_pat = {m_pat, "."};
      else             m_pat = {m_pat, "-"};
      m_mark = 0;
      m_zero = 1;
      if (m_pat.len() == 5) begin exp_err = 1; m_in_letter = 0; m_drain = 1; end
    end else begin
      m_zero++;
      if (m_zero == GAP_TICKS) begin
        m_in_letter = 0;
        hit = -1;
        for (int i = 0; i < 8; i++) if (m_pat == patterns[i]) hit = i;
        if (hit >= 0) begin exp_letter = hit; exp_valid = 1; end
        else exp_err = 1;
      end
    end
    exp_busy = m_in_letter | m_drain;
  endtask

  // Called one time unit after a tick-aligned edge; the bit is sampled TICK_DIV clocks later.
  task automatic send_bit(input bit b);
    morse_in = b;
    model_step(b);
    for (int c = 1; c <= TICK_DIV; c++) begin
      @(posedge clock);
      #1;
      if (c < TICK_DIV) begin
        check("quiet_valid", letter_valid, 0);
        check("quiet_error", decode_error, 0);
      end else begin
        check("valid", letter_valid, exp_valid);
        check("error", decode_error, exp_err);
        check("letter", letter, exp_letter);
        check("busy", busy, exp_busy);
        check("exclusive", letter_valid & decode_error, 0);
      end
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_bit(s[i] == "1");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    morse_in = 1'b0;
    @(posedge clock);
    #1;
    model_reset();
    check("rst_letter", letter, 0);
    check("rst_valid", letter_valid, 0);
    check("rst_error", decode_error, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
  endtask

  task automatic send_random_letter();
    int n, len, pick;
    string p;
    if ($urandom_range(0, 1) == 1) begin
      pick = $urandom_range(0, 7);
      p = patterns[pick];
      for (int i = 0; i < p.len(); i++) begin
        len = (p[i] == "-") ? 3 : 1;
        for (int k = 0; k < len; k++) send_bit(1);
        len = (i == p.len() - 1) ? $urandom_range(3, 5) : $urandom_range(1, 2);
        for (int k = 0; k < len; k++) send_bit(0);
      end
    end else begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        pick = $urandom_range(0, 9);
        len = (pick < 5) ? 1 : (pick < 9) ? $urandom_range(2, 3) : 4;
        for (int k = 0; k < len; k++) send_bit(1);
        len = (i == n - 1) ? $urandom_range(3, 5) : $urandom_range(1, 2);
        for (int k = 0; k < len; k++) send_bit(0);
      end
    end
  endtask

  initial begin
    patterns[0] = "...";  patterns[1] = "-";    patterns[2] = "..-";  patterns[3] = "...-";
    patterns[4] = ".--";  patterns[5] = "-..-"; patterns[6] = "-.--"; patterns[7] = "--..";
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    send_str("1010100000");                       // S
    send_str("11101110101000");                   // Z
    send_str("11101010111000");                   // X
    send_str("1111000");                          // over-long mark
    send_str("111000");                           // T
    send_str("101010101000");                     // five dots
    send_str("11101110111000");                   // O, not in table
    send_str("11101");                            // partial Y, then reset
    do_reset();
    send_str("10101110000");                      // U
    do_reset();
    for (int i = 0; i < 100; i++) send_bit(0);    // idle line

    for (int i = 0; i < 40; i++) begin
      send_random_letter();
      if ($urandom_range(0, 7) == 0) send_bit(0);
    end
    repeat (GAP_TICKS + 1) send_bit(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
